rv_fetch_queue: RTL and testbench
=================================

# rv_fetch_queue

Parametrised instruction queue between the fetch stage and the decode stage of the RV32 pipeline. It replaces the single fetch/decode pipeline register with a DEPTH-entry FIFO of {PC, instruction} pairs, using a valid/ready handshake on both sides. It supports an optional empty-queue bypass and a single-cycle flush on a taken branch or jump redirect (PC_R). Fetch can then run ahead of a stalled decode without losing instructions.

## Interface
- XLEN, 32: width of both the PC field and the instruction field.
- DEPTH, 4: number of entries. Must be a power of two, ≥2.
- BYPASS, 1: 1 = a push into an empty queue is visible on the pop side in the same cycle. 0 = always registered.
- AF_LEVEL, DEPTH-1: `almost_full` asserts when `count` ≥ AF_LEVEL. Legal range is 1..DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discards all entries; sampled on the clock edge.
- push_valid  in  1  fetch presents an instruction.
- push_pc  in  XLEN  PC of the pushed instruction.
- push_instr  in  XLEN  pushed instruction word.
- push_ready  out  1  queue accepts a push this cycle.
- pop_valid  out  1  head entry (or bypass data) is valid.
- pop_pc  out  XLEN  PC of the head entry.
- pop_instr  out  XLEN  instruction of the head entry.
- pop_ready  in  1  decode consumes the head this cycle.
- count  out  $clog2(DEPTH+1)  number of stored entries (bypass data is not counted).
- almost_full  out  1  count ≥ AF_LEVEL.

## Operation
- Storage is a DEPTH-entry array with read and write pointers of $clog2(DEPTH) bits each. Both pointers wrap modulo DEPTH. `count` is held in its own register.
- push_fire = push_valid & push_ready. pop_fire = pop_valid & pop_ready.
- push_ready = rst & !flush & (count < DEPTH). push_ready does not depend on pop_ready, so there is no combinational path from decode to fetch.
- pop_valid = !flush & ((count > 0) | (BYPASS & push_valid & count == 0)).
- pop_pc/pop_instr select the array head when count > 0, otherwise push_pc/push_instr. The array head wins whenever count > 0.
- Bypass fire: count == 0, BYPASS = 1, push_fire and pop_fire in the same cycle. The entry passes straight through; it is not written and neither pointer nor count moves.
- Update rules, applied in priority order:
  - flush: pointers ← 0 and count ← 0. Any push or pop in that cycle is ignored.
  - bypass fire: no state change.
  - otherwise: push_fire writes the array at wptr and increments wptr. pop_fire increments rptr. count changes by +1 (push only), −1 (pop only) or 0 (both, or neither).
- Simultaneous push and pop at count == DEPTH cannot happen, because push_ready is 0 when full.
- Simultaneous push and pop at 0 < count < DEPTH: both complete and count is unchanged.
- Data is not checked for X. Array contents are not reset; only the pointers and count are.

## Timing
- Reset (rst = 0, asynchronous): rptr = wptr = 0, count = 0, almost_full = 0, pop_valid = 0, push_ready = 0. push_ready rises combinationally once rst deasserts.
- Reset asserted mid-operation discards all entries immediately, with no clock edge required.
- Latency from push to pop:
  - BYPASS = 1 and queue empty: 0 cycles, combinational.
  - Otherwise: 1 cycle. The entry is visible on pop in the cycle after its push edge.
- Throughput: one push and one pop per cycle, sustained at any count from 1 to DEPTH−1.
- Flush: during the flush cycle, pop_valid = 0 and push_ready = 0. From the next cycle the queue is empty and accepts pushes. An instruction presented by fetch during the flush cycle is dropped; fetch must re-present its redirect-target instruction in the following cycle.
- count and almost_full are registered and update on the edge after the push or pop that changes them.

## Test plan
- Reset then fill: with pop_ready = 0, push PCs 0x0, 0x4, 0x8, 0xC. Required: count 1→4; almost_full asserts at count 3 (DEPTH = 4); push_ready = 0 once count = 4; the fifth push is held without loss.
- Drain in order: from full, pop_ready = 1 for 4 cycles. Required: pop_pc reads 0x0, 0x4, 0x8, 0xC; count falls to 0; pop_valid = 0 on the fifth cycle.
- Bypass: with the queue empty, BYPASS = 1, push 0x100 with pop_ready = 1. Required: pop_pc = 0x100 in the same cycle and count stays 0. With BYPASS = 0: pop_valid = 0 in that cycle, and pop_pc = 0x100 in the next cycle.
- Wrap-around: run 10 cycles of continuous push and pop at count = 2, with PCs incrementing by 4. Required: output order matches input order across both pointer wraps; count stays 2.
- Flush with simultaneous push: at count = 3, assert flush together with push_valid = 1 (PC 0x200). Required: pop_valid = 0 and push_ready = 0 in that cycle; count = 0 next cycle; 0x200 is never popped.
- Async reset mid-stream: at count = 2, pulse rst low between clock edges. Required: count = 0 and pop_valid = 0 immediately; no stale entry appears after release.

Source files
------------

// File: rtl/rv_fetch_queue.sv
// ============================================================================
// Module   : rv_fetch_queue
// Brief    : Fetch-to-decode instruction FIFO of {PC, instr} with optional
//            empty-queue bypass and single-cycle redirect flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rv_fetch_queue #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int BYPASS   = 1,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_valid,
  input  logic [XLEN-1:0]            push_pc,
  input  logic [XLEN-1:0]            push_instr,
  output logic                       push_ready,
  output logic                       pop_valid,
  output logic [XLEN-1:0]            pop_pc,
  output logic [XLEN-1:0]            pop_instr,
  input  logic                       pop_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int                  c_PW    = $clog2(DEPTH);
  localparam int                  c_CW    = $clog2(DEPTH + 1);
  localparam logic [c_CW-1:0]     c_FULL  = c_CW'(DEPTH);
  localparam logic [c_CW-1:0]     c_AF    = c_CW'(AF_LEVEL);
  localparam logic                c_BYP   = (BYPASS != 0);

  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [XLEN-1:0] r_mem_instr [DEPTH];
  logic [c_PW-1:0] r_rptr;
  logic [c_PW-1:0] r_wptr;
  logic [c_CW-1:0] r_count;
  logic            r_af;

  logic            w_empty;
  logic            w_full;
  logic            w_push_fire;
  logic            w_pop_fire;
  logic            w_bypass_fire;
  logic [c_CW-1:0] w_count_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);

  // push_ready deliberately ignores pop_ready: no decode-to-fetch comb path.
  assign push_ready = rst & ~flush & ~w_full;
  assign pop_valid  = ~flush & (~w_empty | (c_BYP & push_valid & w_empty));
  assign pop_pc     = w_empty ? push_pc    : r_mem_pc[r_rptr];
  assign pop_instr  = w_empty ? push_instr : r_mem_instr[r_rptr];

  assign w_push_fire   = push_valid & push_ready;
  assign w_pop_fire    = pop_valid & pop_ready;
  assign w_bypass_fire = c_BYP & w_empty & w_push_fire & w_pop_fire;

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else if (!w_bypass_fire) begin
      if (w_push_fire && !w_pop_fire) begin
        w_count_nxt = r_count + c_CW'(1);
      end else if (!w_push_fire && w_pop_fire) begin
        w_count_nxt = r_count - c_CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_af    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_af    <= (w_count_nxt >= c_AF);
      if (flush) begin
        r_rptr <= '0;
        r_wptr <= '0;
      end else if (!w_bypass_fire) begin
        if (w_push_fire) begin
          r_wptr <= r_wptr + c_PW'(1);
        end
        if (w_pop_fire) begin
          r_rptr <= r_rptr + c_PW'(1);
        end
      end
    end
  end

  // Payload storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_push_fire && !w_bypass_fire) begin
      r_mem_pc[r_wptr]    <= push_pc;
      r_mem_instr[r_wptr] <= push_instr;
    end
  end

  assign count       = r_count;
  assign almost_full = r_af;

endmodule

`default_nettype wire

// File: tb/tb_rv_fetch_queue.sv
// ============================================================================
// Module   : tb_rv_fetch_queue
// Brief    : Directed self-checking bench for rv_fetch_queue (bypass and
//            registered variants side by side).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rv_fetch_queue;

  localparam int c_XLEN = 32;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              push_valid;
  logic [c_XLEN-1:0] push_pc;
  logic [c_XLEN-1:0] push_instr;
  logic              pop_ready;

  logic              push_ready,  nb_push_ready;
  logic              pop_valid,   nb_pop_valid;
  logic [c_XLEN-1:0] pop_pc,      nb_pop_pc;
  logic [c_XLEN-1:0] pop_instr,   nb_pop_instr;
  logic [2:0]        count,       nb_count;
  logic              almost_full, nb_almost_full;

  int n_checks = 0;
  int n_fail   = 0;

  rv_fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(1), .AF_LEVEL(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr),
    .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_pc(pop_pc), .pop_instr(pop_instr),
    .pop_ready(pop_ready),
    .count(count), .almost_full(almost_full)
  );

  rv_fetch_queue #(.XLEN(32), .DEPTH(4), .BYPASS(0), .AF_LEVEL(3)) dut_nb (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr),
    .push_ready(nb_push_ready),
    .pop_valid(nb_pop_valid), .pop_pc(nb_pop_pc), .pop_instr(nb_pop_instr),
    .pop_ready(pop_ready),
    .count(nb_count), .almost_full(nb_almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic drive(input logic pv, input logic [31:0] pc, input logic pr, input logic fl);
    push_valid = pv;
    push_pc    = pc;
    push_instr = instr_of(pc);
    pop_ready  = pr;
    flush      = fl;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    check("rst_count",      32'(count), 32'd0);
    check("rst_pop_valid",  32'(pop_valid), 32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd0);
    check("rst_af",         32'(almost_full), 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    check("rst_release_push_ready", 32'(push_ready), 32'd1);

    // Fill with decode stalled.
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
      check($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
      check($sformatf("fill_af_%0d", i), 32'(almost_full), (i >= 3) ? 32'd1 : 32'd0);
      check($sformatf("fill_ready_%0d", i), 32'(push_ready), 32'd1);
      cyc();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      check($sformatf("full_ready_%0d", i), 32'(push_ready), 32'd0);
      check($sformatf("full_count_%0d", i), 32'(count), 32'd4);
      check($sformatf("full_af_%0d", i), 32'(almost_full), 32'd1);
      cyc();
    end

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      check($sformatf("drain_valid_%0d", i), 32'(pop_valid), 32'd1);
      check($sformatf("drain_pc_%0d", i), pop_pc, 32'(4 * i));
      check($sformatf("drain_instr_%0d", i), pop_instr, instr_of(32'(4 * i)));
      check($sformatf("drain_count_%0d", i), 32'(count), 32'(4 - i));
      cyc();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_empty_valid", 32'(pop_valid), 32'd0);
    check("drain_empty_count", 32'(count), 32'd0);
    check("drain_empty_af",    32'(almost_full), 32'd0);
    cyc();

    // Bypass vs registered path.
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    check("byp_valid",    32'(pop_valid), 32'd1);
    check("byp_pc",       pop_pc, 32'h100);
    check("byp_instr",    pop_instr, instr_of(32'h100));
    check("nobyp_valid",  32'(nb_pop_valid), 32'd0);
    cyc();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("byp_count_after", 32'(count), 32'd0);
    check("byp_valid_after", 32'(pop_valid), 32'd0);
    check("nobyp_count",     32'(nb_count), 32'd1);
    check("nobyp_valid_nxt", 32'(nb_pop_valid), 32'd1);
    check("nobyp_pc_nxt",    nb_pop_pc, 32'h100);
    cyc();
    check("nobyp_count_end", 32'(nb_count), 32'd0);

    // Wrap-around at steady count 2.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      cyc();
    end
    check("wrap_start_count", 32'(count), 32'd2);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h308 + 32'(4 * k), 1'b1, 1'b0);
      check($sformatf("wrap_pc_%0d", k), pop_pc, 32'h300 + 32'(4 * k));
      check($sformatf("wrap_count_%0d", k), 32'(count), 32'd2);
      cyc();
    end
    check("wrap_end_count", 32'(count), 32'd2);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("wrap_end_head", pop_pc, 32'h328);
    check("wrap_end_instr", pop_instr, instr_of(32'h328));

    // Flush with a simultaneous push at count 3.
    drive(1'b1, 32'h330, 1'b0, 1'b0);
    cyc();
    check("pre_flush_count", 32'(count), 32'd3);
    check("pre_flush_af",    32'(almost_full), 32'd1);
    drive(1'b1, 32'h200, 1'b1, 1'b1);
    check("flush_pop_valid",  32'(pop_valid), 32'd0);
    check("flush_push_ready", 32'(push_ready), 32'd0);
    cyc();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("post_flush_count", 32'(count), 32'd0);
    check("post_flush_valid", 32'(pop_valid), 32'd0);
    check("post_flush_ready", 32'(push_ready), 32'd1);
    check("post_flush_af",    32'(almost_full), 32'd0);
    drive(1'b1, 32'h204, 1'b1, 1'b0);
    check("redirect_pc", pop_pc, 32'h204);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("redirect_count", 32'(count), 32'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_arst_count", 32'(count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count",      32'(count), 32'd0);
    check("arst_pop_valid",  32'(pop_valid), 32'd0);
    check("arst_push_ready", 32'(push_ready), 32'd0);
    #2;
    rst = 1'b1;
    cyc();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("post_arst_valid", 32'(pop_valid), 32'd0);
    check("post_arst_count", 32'(count), 32'd0);
    drive(1'b1, 32'h500, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("post_arst_push_count", 32'(count), 32'd1);
    check("post_arst_head",       pop_pc, 32'h500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
